// File: rtl/cp0_unit.sv
// cp0_unit: system control coprocessor for the pipelined core.
// Holds STATUS/CAUSE/EPC/EHB/PTB/IMASK and captures exception state.
// Masks 32 level-sensitive device lines into one interrupt request.
// The lowest-numbered pending line is encoded into hw_cause.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cp0_addr_i          register select for MFC0 read and MTC0 write
//   cp0_data_i          MTC0 write data
//   cp0_we_i            MTC0 write enable
//   cp0_data_o          combinational MFC0 read data
//   cp0_epc_o           EPC export (ERET target)
//   cp0_ehb_o           exception handler base export
//   cp0_ptb_o           page-table base export (to MMU)
//   exception           one-cycle pulse: exception taken, with cause/epc
//   cause, epc          cause word and return PC captured on exception
//   eret                one-cycle pulse: ERET retired, clears EXL
//   hw_interrupt        level interrupt request to the core
//   hw_cause            cause word for the highest-priority pending line
//   devices_interrupt   device interrupt lines, bit n = line n
module cp0_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_data_i,
  input  logic        cp0_we_i,
  output logic [31:0] cp0_data_o,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] cp0_ehb_o,
  output logic [31:0] cp0_ptb_o,
  input  logic        exception,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  input  logic        eret,
  output logic        hw_interrupt,
  output logic [31:0] hw_cause,
  input  logic [31:0] devices_interrupt
);

  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;
  localparam logic [4:0] AddrEhb    = 5'd15;
  localparam logic [4:0] AddrPtb    = 5'd16;
  localparam logic [4:0] AddrImask  = 5'd17;
  localparam logic [4:0] AddrIpend  = 5'd18;

  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ehb_q, ehb_d;
  logic [31:0] ptb_q, ptb_d;
  logic [31:0] imask_q, imask_d;

  logic [31:0] pending;
  logic [4:0]  irq_idx;

  // Next state: software write first, then eret, then exception, so the
  // later assignments win in exactly the fields they own.
  always_comb begin
    ie_d    = ie_q;
    exl_d   = exl_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    ehb_d   = ehb_q;
    ptb_d   = ptb_q;
    imask_d = imask_q;

    if (cp0_we_i) begin
      case (cp0_addr_i)
        AddrStatus: begin
          ie_d  = cp0_data_i[0];
          exl_d = cp0_data_i[1];
        end
        AddrCause: cause_d = cp0_data_i;
        AddrEpc:   epc_d   = cp0_data_i;
        AddrEhb:   ehb_d   = cp0_data_i;
        AddrPtb:   ptb_d   = cp0_data_i;
        AddrImask: imask_d = cp0_data_i;
        default: ;
      endcase
    end

    if (eret) begin
      exl_d = 1'b0;
    end

    if (exception) begin
      exl_d   = 1'b1;
      cause_d = cause;
      epc_d   = epc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      cause_q <= '0;
      epc_q   <= '0;
      ehb_q   <= '0;
      ptb_q   <= '0;
      imask_q <= '0;
    end else begin
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      ehb_q   <= ehb_d;
      ptb_q   <= ptb_d;
      imask_q <= imask_d;
    end
  end

  assign pending = devices_interrupt & imask_q;

  // Scan from the top down so the lowest set line is the last one written.
  always_comb begin
    irq_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending[i]) begin
        irq_idx = 5'(i);
      end
    end
  end

  assign hw_interrupt = ie_q & ~exl_q & (|pending);
  assign hw_cause     = (|pending) ? {1'b1, 26'b0, irq_idx} : 32'h0;

  always_comb begin
    cp0_data_o = '0;
    case (cp0_addr_i)
      AddrStatus: cp0_data_o = {30'b0, exl_q, ie_q};
      AddrCause:  cp0_data_o = cause_q;
      AddrEpc:    cp0_data_o = epc_q;
      AddrEhb:    cp0_data_o = ehb_q;
      AddrPtb:    cp0_data_o = ptb_q;
      AddrImask:  cp0_data_o = imask_q;
      AddrIpend:  cp0_data_o = pending;
      default:    cp0_data_o = '0;
    endcase
  end

  assign cp0_epc_o = epc_q;
  assign cp0_ehb_o = ehb_q;
  assign cp0_ptb_o = ptb_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  cp0_addr_i;
  logic [31:0] cp0_data_i;
  logic        cp0_we_i;
  logic [31:0] cp0_data_o;
  logic [31:0] cp0_epc_o;
  logic [31:0] cp0_ehb_o;
  logic [31:0] cp0_ptb_o;
  logic        exception;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        eret;
  logic        hw_interrupt;
  logic [31:0] hw_cause;
  logic [31:0] devices_interrupt;

  int vectors;
  int miscompares;

  cp0_unit dut (
    .clk               (clk),
    .rst               (rst),
    .cp0_addr_i        (cp0_addr_i),
    .cp0_data_i        (cp0_data_i),
    .cp0_we_i          (cp0_we_i),
    .cp0_data_o        (cp0_data_o),
    .cp0_epc_o         (cp0_epc_o),
    .cp0_ehb_o         (cp0_ehb_o),
    .cp0_ptb_o         (cp0_ptb_o),
    .exception         (exception),
    .cause             (cause),
    .epc               (epc),
    .eret              (eret),
    .hw_interrupt      (hw_interrupt),
    .hw_cause          (hw_cause),
    .devices_interrupt (devices_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Combinational read of one register; leaves the address applied.
  task automatic rd(input logic [4:0] addr, output logic [31:0] val);
    cp0_addr_i = addr;
    #1;
    val = cp0_data_o;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    rd(addr, v);
    chk(tag, v, exp);
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    cp0_addr_i = addr;
    cp0_data_i = data;
    cp0_we_i   = 1'b1;
    tick();
    cp0_we_i   = 1'b0;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst               = 1'b1;
    cp0_addr_i        = '0;
    cp0_data_i        = '0;
    cp0_we_i          = 1'b0;
    exception         = 1'b0;
    cause             = '0;
    epc               = '0;
    eret              = 1'b0;
    devices_interrupt = 32'hFFFF_FFFF;

    // Reset with every line high
    tick();
    tick();
    chk("rst_hw_int", {31'b0, hw_interrupt}, 32'h0);
    chk("rst_hw_cause", hw_cause, 32'h0);
    chk("rst_epc", cp0_epc_o, 32'h0);
    chk("rst_ehb", cp0_ehb_o, 32'h0);
    chk("rst_ptb", cp0_ptb_o, 32'h0);
    for (int a = 12; a <= 18; a++) begin
      rd_chk($sformatf("rst_rd%0d", a), 5'(a), 32'h0);
    end

    rst = 1'b0;
    devices_interrupt = '0;
    tick();

    // Register read/write
    wr(5'd15, 32'h0000_0040);
    chk("ehb_export", cp0_ehb_o, 32'h0000_0040);
    wr(5'd16, 32'h0001_0000);
    chk("ptb_export", cp0_ptb_o, 32'h0001_0000);
    rd_chk("ehb_read", 5'd15, 32'h0000_0040);
    wr(5'd20, 32'h0000_1234);
    rd_chk("unmapped_read", 5'd20, 32'h0);
    wr(5'd12, 32'hFFFF_FFFC);
    rd_chk("status_trunc", 5'd12, 32'h0);

    // Interrupt gating
    wr(5'd17, 32'h0000_0002);
    wr(5'd12, 32'h0000_0001);
    chk("no_line_int", {31'b0, hw_interrupt}, 32'h0);
    devices_interrupt = 32'h0000_0002;
    #1;
    chk("line1_int", {31'b0, hw_interrupt}, 32'h1);
    chk("line1_cause", hw_cause, 32'h8000_0001);
    rd_chk("ipend", 5'd18, 32'h0000_0002);
    wr(5'd12, 32'h0000_0000);
    chk("ie_off_int", {31'b0, hw_interrupt}, 32'h0);
    wr(5'd12, 32'h0000_0001);
    chk("ie_on_int", {31'b0, hw_interrupt}, 32'h1);
    wr(5'd17, 32'h0000_0000);
    chk("mask_off_int", {31'b0, hw_interrupt}, 32'h0);
    chk("mask_off_cause", hw_cause, 32'h0);
    wr(5'd17, 32'h0000_0002);
    chk("mask_on_int", {31'b0, hw_interrupt}, 32'h1);

    // Exception entry
    exception = 1'b1;
    cause     = 32'h8000_0001;
    epc       = 32'h0000_0024;
    tick();
    exception = 1'b0;
    #1;
    chk("exc_hw_int", {31'b0, hw_interrupt}, 32'h0);
    chk("exc_epc_port", cp0_epc_o, 32'h0000_0024);
    rd_chk("exc_epc", 5'd14, 32'h0000_0024);
    rd_chk("exc_cause", 5'd13, 32'h8000_0001);
    rd_chk("exc_status", 5'd12, 32'h0000_0003);

    // ERET with line 1 still high
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    rd_chk("eret_status", 5'd12, 32'h0000_0001);
    chk("eret_hw_int", {31'b0, hw_interrupt}, 32'h1);
    devices_interrupt = 32'h0;
    #1;
    chk("drop_hw_int", {31'b0, hw_interrupt}, 32'h0);

    // Exception beats a simultaneous EPC write
    exception  = 1'b1;
    cause      = 32'h0000_000C;
    epc        = 32'h0000_0088;
    cp0_addr_i = 5'd14;
    cp0_data_i = 32'h0000_DEAD;
    cp0_we_i   = 1'b1;
    tick();
    exception = 1'b0;
    cp0_we_i  = 1'b0;
    #1;
    rd_chk("coll_epc", 5'd14, 32'h0000_0088);
    rd_chk("coll_cause", 5'd13, 32'h0000_000C);
    rd_chk("coll_status", 5'd12, 32'h0000_0003);

    // ERET beats the EXL field of a STATUS write; IE takes the written 0
    eret       = 1'b1;
    cp0_addr_i = 5'd12;
    cp0_data_i = 32'h0000_0002;
    cp0_we_i   = 1'b1;
    tick();
    eret     = 1'b0;
    cp0_we_i = 1'b0;
    #1;
    rd_chk("eret_wr_status", 5'd12, 32'h0000_0000);

    // Priority encoding
    wr(5'd12, 32'h0000_0001);
    wr(5'd17, 32'hFFFF_FFFF);
    devices_interrupt = 32'h0000_0028;
    #1;
    chk("prio_3_5", hw_cause, 32'h8000_0003);
    devices_interrupt = 32'h8000_0000;
    #1;
    chk("prio_31", hw_cause, 32'h8000_001F);
    devices_interrupt = 32'h0000_0001;
    #1;
    chk("prio_0", hw_cause, 32'h8000_0000);
    chk("prio_0_int", {31'b0, hw_interrupt}, 32'h1);

    // Asynchronous reset away from any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_int", {31'b0, hw_interrupt}, 32'h0);
    chk("async_rst_cause", hw_cause, 32'h0);
    chk("async_rst_epc", cp0_epc_o, 32'h0);
    chk("async_rst_ehb", cp0_ehb_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
